// File: rtl/addseq_ctrl_8.sv
// rtl/addseq_ctrl_8.sv - byte-serial multi-byte add sequencer around one 8-bit adder
// Optional subtract mode (extra `sub` input) is enabled by defining ADDSEQ_SUB_EN.

module bitadder_8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       cin,
  output logic       cout,
  output logic [7:0] S
);
  assign {cout, S} = {1'b0, A} + {1'b0, B} + {8'd0, cin};
endmodule

module addseq_ctrl_8 #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                cin,
`ifdef ADDSEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry;
  logic [IW-1:0]   byte_idx;
  logic [W-1:0]    b_eff;
  logic            carry_init;
  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [7:0]      add_s;
  logic            add_cout;
  logic            accept;
  logic            last;

  // Subtraction is a + ~b + 1; the inversion is applied once at capture.
`ifdef ADDSEQ_SUB_EN
  assign b_eff      = sub ? ~op_b : op_b;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign b_eff      = op_b;
  assign carry_init = cin;
`endif

  assign add_a  = a_reg[{byte_idx, 3'b000} +: 8];
  assign add_b  = b_reg[{byte_idx, 3'b000} +: 8];
  assign accept = (state == IDLE) && start;
  assign last   = (byte_idx == LAST_IDX);

  bitadder_8 u_adder (
    .A    (add_a),
    .B    (add_b),
    .cin  (carry),
    .cout (add_cout),
    .S    (add_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      byte_idx <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      a_reg    <= op_a;
      b_reg    <= b_eff;
      carry    <= carry_init;
      byte_idx <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (state == ADD) begin
      sum[{byte_idx, 3'b000} +: 8] <= add_s;
      carry <= add_cout;
      if (last) begin
        // Index stays at the last byte; it is reloaded on the next accept.
        cout <= add_cout;
        ovf  <= (a_reg[W-1] == b_reg[W-1]) && (add_s[7] != a_reg[W-1]);
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addseq_ctrl_8.sv
// tb/tb_addseq_ctrl_8.sv - directed self-checking bench for addseq_ctrl_8 (NBYTES=4)

module tb_addseq_ctrl_8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cin;
`ifdef ADDSEQ_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  addseq_ctrl_8 #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
`ifdef ADDSEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and watches 8 falling-edge samples after the start edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s,
                        input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [31:0] sum_at_done;
    logic cout_at_done;
    logic ovf_at_done;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    sum_at_done = 'x; cout_at_done = 1'bx; ovf_at_done = 1'bx;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
`ifdef ADDSEQ_SUB_EN
    sub = s;
`else
    if (s) $display("note: sub ignored in add-only build");
`endif
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; cin = ~c;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = n;
        sum_at_done = sum; cout_at_done = cout; ovf_at_done = ovf;
      end
    end
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd4);
    check({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, ".done_at"}, 64'(done_at), 64'd5);
    check({tag, ".sum"}, 64'(sum_at_done), 64'(exp_sum));
    check({tag, ".cout"}, 64'(cout_at_done), 64'(exp_cout));
    check({tag, ".ovf"}, 64'(ovf_at_done), 64'(exp_ovf));
    check({tag, ".sum_held"}, 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
`ifdef ADDSEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.sum", 64'(sum), 64'd0);
    check("rst.cout", 64'(cout), 64'd0);
    check("rst.ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.busy", 64'(busy), 64'd0);
    check("idle.done", 64'(done), 64'd0);
    check("idle.sum", 64'(sum), 64'd0);

    run_op("t2_ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("t3_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("t3_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("t4_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op("chain", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);

    // start held high: a single done, then re-accept from the IDLE cycle after DONE
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; cin = 1'b0; start = 1'b1;
    done_cnt = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (n == 5) check("t5_held.sum", 64'(sum), 64'h2345_6789);
      if (n == 6) check("t5_held.idle_busy", 64'(busy), 64'd0);
    end
    check("t5_held.done_pulses", 64'(done_cnt), 64'd1);
    @(negedge clk);
    check("t5_held.reaccept_busy", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    check("t5_midop.sum_partial", 64'(sum), 64'h0000_0089);
    rst_n = 1'b0;
    #1;
    check("t5_midop.busy", 64'(busy), 64'd0);
    check("t5_midop.sum", 64'(sum), 64'd0);
    check("t5_midop.cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("t5_midop.no_done", 64'(done_cnt), 64'd0);
    check("t5_midop.sum_after", 64'(sum), 64'd0);

`ifdef ADDSEQ_SUB_EN
    run_op("t6_sub", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
